// File: rtl/fp_alu_seq.sv
// Multi-cycle IEEE-754-style floating-point add/sub/mul/div on one shared datapath sequenced by an FSM.
// Results truncate toward zero. Denormals are flushed to zero on the way in and on the way out.
module fp_alu_seq #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [1:0]           op,
   input  logic [EXP_W+MAN_W:0] in_a,
   input  logic [EXP_W+MAN_W:0] in_b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] out,
   output logic [3:0]           flags
);
   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int SW   = MAN_W + 1;
   localparam int AW   = 2 * SW;
   localparam int G    = 2;
   localparam int XW   = EXP_W + $clog2(AW) + 3;
   localparam int CW   = $clog2(MAN_W + 2) + 1;
   localparam int BIAS = (1 << (EXP_W - 1)) - 1;
   localparam logic [EXP_W-1:0]     EXP_MAX = '1;
   localparam logic signed [XW-1:0] BIAS_X  = XW'(BIAS);
   localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11;

   typedef enum logic [2:0] {IDLE, UNPACK, EXEC, NORM, DONE} state_t;

   function automatic logic [W-1:0] inf_word(input logic s);
      return {s, EXP_MAX, {MAN_W{1'b0}}};
   endfunction

   function automatic logic [W-1:0] nan_word();
      return {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};
   endfunction

   // m carries weight 1 at bit AW-2; returns {word, flags} after normalise, truncate, range checks.
   function automatic logic [W+3:0] norm_pack(input logic [AW-1:0] m, input logic signed [XW-1:0] e,
                                               input logic s, input logic zero_pos);
      int p;
      int ne;
      logic [MAN_W-1:0] frac;
      p = 0;
      for (int i = 0; i < AW; i++)
         if (m[i]) p = i;
      frac = MAN_W'((m << (AW - 1 - p)) >> (AW - 1 - MAN_W));
      ne   = int'(e) + p - (AW - 2);
      if (m == '0)
         return {s & ~zero_pos, {(W-1){1'b0}}, 4'b0000};
      else if (ne >= (1 << EXP_W) - 1)
         return {inf_word(s), 4'b0010};
      else if (ne <= 0)
         return {s, {(W-1){1'b0}}, 4'b0001};
      else
         return {s, EXP_W'(ne), frac, 4'b0000};
   endfunction

   state_t                 state;
   logic [CW-1:0]          cnt;
   logic [1:0]             op_q;
   logic [W-1:0]           a_q, b_q;
   logic                   sa_q, sb_q, sx_q, spc_q;
   logic [EXP_W-1:0]       ea_q, eb_q;
   logic [SW-1:0]          ma_q, mb_q, mplier_q;
   logic [W+3:0]           spc_res_q;
   logic signed [XW-1:0]   e_q;
   logic [AW-1:0]          acc_q, mcand_q;
   logic [SW:0]            rem_q, quo_q;

   logic [EXP_W-1:0]       ea, eb;
   logic                   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sa, sb, sx, spc;
   logic [SW-1:0]          ma, mb;
   logic [W+3:0]           spc_res;
   logic signed [XW-1:0]   ea_x, eb_x, e_md;

   logic                   a_ge, sl;
   logic [EXP_W-1:0]       el, es;
   logic [SW-1:0]          ml, ms;
   logic [SW+G:0]          sum;
   logic [AW-1:0]          norm_in;
   logic [W+3:0]           norm_res;

   // Operand classification and special-result selection, evaluated during UNPACK
   always_comb begin
      ea      = a_q[W-2 -: EXP_W];
      eb      = b_q[W-2 -: EXP_W];
      a_zero  = (ea == '0);
      b_zero  = (eb == '0);
      a_inf   = (ea == EXP_MAX) && (a_q[MAN_W-1:0] == '0);
      b_inf   = (eb == EXP_MAX) && (b_q[MAN_W-1:0] == '0);
      a_nan   = (ea == EXP_MAX) && !a_inf;
      b_nan   = (eb == EXP_MAX) && !b_inf;
      sa      = a_q[W-1];
      sb      = b_q[W-1] ^ (op_q == OP_SUB);
      sx      = sa ^ sb;
      ma      = a_zero ? '0 : {1'b1, a_q[MAN_W-1:0]};
      mb      = b_zero ? '0 : {1'b1, b_q[MAN_W-1:0]};
      ea_x    = XW'(ea);
      eb_x    = XW'(eb);
      e_md    = (op_q == OP_DIV) ? (ea_x - eb_x + BIAS_X) : (ea_x + eb_x - BIAS_X);
      spc     = 1'b0;
      spc_res = '0;
      if (a_nan || b_nan) begin
         spc     = 1'b1;
         spc_res = {nan_word(), 4'b1000};
      end else begin
         case (op_q)
            OP_ADD, OP_SUB: begin
               if (a_inf && b_inf && (sa != sb)) begin
                  spc = 1'b1; spc_res = {nan_word(), 4'b1000};
               end else if (a_inf) begin
                  spc = 1'b1; spc_res = {inf_word(sa), 4'b0000};
               end else if (b_inf) begin
                  spc = 1'b1; spc_res = {inf_word(sb), 4'b0000};
               end
            end
            OP_MUL: begin
               if ((a_inf && b_zero) || (a_zero && b_inf)) begin
                  spc = 1'b1; spc_res = {nan_word(), 4'b1000};
               end else if (a_inf || b_inf) begin
                  spc = 1'b1; spc_res = {inf_word(sx), 4'b0000};
               end
            end
            default: begin
               if ((a_zero && b_zero) || (a_inf && b_inf)) begin
                  spc = 1'b1; spc_res = {nan_word(), 4'b1000};
               end else if (a_inf) begin
                  spc = 1'b1; spc_res = {inf_word(sx), 4'b0000};
               end else if (b_zero) begin
                  spc = 1'b1; spc_res = {inf_word(sx), 4'b0100};
               end else if (b_inf) begin
                  spc = 1'b1; spc_res = {sx, {(W-1){1'b0}}, 4'b0000};
               end
            end
         endcase
      end
   end

   // Add/sub alignment: the smaller magnitude is shifted right, bits below the guard bits are lost
   always_comb begin
      a_ge = {ea_q, ma_q} >= {eb_q, mb_q};
      el   = a_ge ? ea_q : eb_q;
      es   = a_ge ? eb_q : ea_q;
      ml   = a_ge ? ma_q : mb_q;
      ms   = a_ge ? mb_q : ma_q;
      sl   = a_ge ? sa_q : sb_q;
      if (sa_q != sb_q)
         sum = {1'b0, ml, {G{1'b0}}} - ({1'b0, ms, {G{1'b0}}} >> (el - es));
      else
         sum = {1'b0, ml, {G{1'b0}}} + ({1'b0, ms, {G{1'b0}}} >> (el - es));
      norm_in  = (op_q == OP_DIV) ? (AW'(quo_q) << (MAN_W - 1)) : acc_q;
      norm_res = spc_q ? spc_res_q : norm_pack(norm_in, e_q, sx_q, !op_q[1]);
   end

   always_ff @(posedge clk) begin
      case (state)
         IDLE: begin
            if (in_valid && in_ready) begin
               op_q <= op;
               a_q  <= in_a;
               b_q  <= in_b;
            end
         end
         UNPACK: begin
            sa_q      <= sa;
            sb_q      <= sb;
            sx_q      <= sx;
            ea_q      <= ea;
            eb_q      <= eb;
            ma_q      <= ma;
            mb_q      <= mb;
            spc_q     <= spc;
            spc_res_q <= spc_res;
            e_q       <= e_md;
            acc_q     <= '0;
            mcand_q   <= AW'(mb);
            mplier_q  <= ma;
            rem_q     <= {1'b0, ma};
            quo_q     <= '0;
         end
         EXEC: begin
            case (op_q)
               OP_MUL: begin
                  if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                  mcand_q  <= mcand_q << 1;
                  mplier_q <= mplier_q >> 1;
               end
               OP_DIV: begin
                  if (rem_q >= {1'b0, mb_q}) begin
                     rem_q <= (rem_q - {1'b0, mb_q}) << 1;
                     quo_q <= {quo_q[SW-1:0], 1'b1};
                  end else begin
                     rem_q <= rem_q << 1;
                     quo_q <= {quo_q[SW-1:0], 1'b0};
                  end
               end
               default: begin
                  acc_q <= AW'(sum) << (MAN_W - G);
                  e_q   <= XW'(el);
                  sx_q  <= sl;
               end
            endcase
         end
         default: ;
      endcase
   end

   // Sequencer: one operation in flight, result held in DONE until out_ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out       <= '0;
         flags     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  state    <= UNPACK;
                  in_ready <= 1'b0;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            UNPACK: begin
               state <= EXEC;
               if (op_q == OP_MUL)      cnt <= CW'(MAN_W);
               else if (op_q == OP_DIV) cnt <= CW'(MAN_W + 1);
               else                     cnt <= '0;
            end
            EXEC: begin
               if (cnt == '0) state <= NORM;
               else           cnt   <= cnt - CW'(1);
            end
            NORM: begin
               {out, flags} <= norm_res;
               out_valid    <= 1'b1;
               state        <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fp_alu_seq.sv
// Directed scoreboard bench for fp_alu_seq at default widths (single precision).
module tb_fp_alu_seq;
   localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11;

   typedef struct packed {
      logic [31:0] res;
      logic [3:0]  fl;
      logic [7:0]  lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  op = 2'b00;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out;
   logic [3:0]  flags;

   int   total = 0;
   int   bad = 0;
   exp_t sb_q[$];

   fp_alu_seq #(.EXP_W(8), .MAN_W(23)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
      .out(out), .flags(flags)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Drives one request from a negedge; returns at the first negedge after the accept edge.
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic [3:0] f, input int l, input bit push);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_wait", {31'b0, in_ready}, 32'd1);
      if (push) sb_q.push_back('{res: r, fl: f, lat: l[7:0]});
      in_valid = 1'b1; op = o; in_a = a; in_b = b;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic collect(input string tag, input bit release_out);
      int   lat;
      exp_t e;
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      e = sb_q.pop_front();
      check({tag, "_lat"}, lat, 32'(e.lat));
      check({tag, "_out"}, out, e.res);
      check({tag, "_flags"}, {28'b0, flags}, {28'b0, e.fl});
      check({tag, "_busy"}, {31'b0, in_ready}, 32'd0);
      if (release_out) begin
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         check({tag, "_vld_drop"}, {31'b0, out_valid}, 32'd0);
         check({tag, "_rdy_rise"}, {31'b0, in_ready}, 32'd1);
      end
   endtask

   initial begin
      int seen;
      #2 rst_n = 1'b0;
      #1;
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_out", out, 32'd0);
      check("rst_flags", {28'b0, flags}, 32'd0);
      check("rst_in_ready", {31'b0, in_ready}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_in_ready", {31'b0, in_ready}, 32'd1);

      issue(OP_ADD, 32'h3F800000, 32'h40000000, 32'h40400000, 4'b0000, 4, 1'b1);
      collect("add_1_2", 1'b1);
      issue(OP_SUB, 32'h3F800000, 32'h3F800000, 32'h00000000, 4'b0000, 4, 1'b1);
      collect("sub_zero", 1'b1);
      issue(OP_ADD, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4'b0010, 4, 1'b1);
      collect("add_ovf", 1'b1);
      issue(OP_MUL, 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 27, 1'b1);
      collect("mul_basic", 1'b1);
      issue(OP_DIV, 32'h40400000, 32'h40000000, 32'h3FC00000, 4'b0000, 28, 1'b1);
      collect("div_basic", 1'b1);
      issue(OP_DIV, 32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 28, 1'b1);
      collect("div_by_zero", 1'b1);
      issue(OP_ADD, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000, 4, 1'b1);
      collect("inf_minus_inf", 1'b1);
      issue(OP_SUB, 32'h40000000, 32'h40400000, 32'hBF800000, 4'b0000, 4, 1'b1);
      collect("sub_neg", 1'b1);
      issue(OP_MUL, 32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000, 27, 1'b1);
      collect("mul_neg", 1'b1);
      issue(OP_DIV, 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0000, 28, 1'b1);
      collect("div_third_rtz", 1'b1);
      issue(OP_MUL, 32'h00800000, 32'h00800000, 32'h00000000, 4'b0001, 27, 1'b1);
      collect("mul_underflow", 1'b1);
      issue(OP_MUL, 32'h00000000, 32'h7F800000, 32'h7FC00000, 4'b1000, 27, 1'b1);
      collect("zero_times_inf", 1'b1);
      issue(OP_ADD, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000, 4, 1'b1);
      collect("nan_in", 1'b1);
      issue(OP_ADD, 32'h00000001, 32'h3F800000, 32'h3F800000, 4'b0000, 4, 1'b1);
      collect("denorm_flush", 1'b1);

      // Backpressure: result held, in_valid pulses ignored
      issue(OP_MUL, 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 27, 1'b1);
      collect("bp", 1'b0);
      for (int i = 0; i < 10; i++) begin
         in_valid = i[0]; op = OP_ADD; in_a = 32'h3F800000; in_b = 32'h3F800000;
         @(negedge clk);
         check("bp_out", out, 32'h40400000);
         check("bp_flags", {28'b0, flags}, 32'd0);
         check("bp_vld", {31'b0, out_valid}, 32'd1);
         check("bp_rdy", {31'b0, in_ready}, 32'd0);
      end
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("done_no_accept", {31'b0, in_ready}, 32'd1);
      check("done_vld_drop", {31'b0, out_valid}, 32'd0);
      in_valid = 1'b0;
      repeat (6) @(negedge clk);
      check("bp_no_extra", {31'b0, out_valid}, 32'd0);
      check("bp_idle_rdy", {31'b0, in_ready}, 32'd1);
      issue(OP_ADD, 32'h3F800000, 32'h40000000, 32'h40400000, 4'b0000, 4, 1'b1);
      collect("after_bp", 1'b1);

      // Reset in the middle of a division aborts it
      issue(OP_DIV, 32'h40400000, 32'h40000000, 32'h3FC00000, 4'b0000, 28, 1'b0);
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_vld", {31'b0, out_valid}, 32'd0);
      check("abort_out", out, 32'd0);
      check("abort_flags", {28'b0, flags}, 32'd0);
      check("abort_rdy", {31'b0, in_ready}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("abort_no_result", seen, 32'd0);
      issue(OP_ADD, 32'h3F800000, 32'h40000000, 32'h40400000, 4'b0000, 4, 1'b1);
      collect("after_reset", 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
